// File: rtl/mem_multi_port_if.sv
// mem_multi_port_if: per-channel valid/ready request bus with read-data and error responses
interface mem_multi_port_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_CH     = 2
);
  logic [NUM_CH-1:0]            valid, wr_rd, ready, rvalid, err;
  logic [NUM_CH*ADDR_WIDTH-1:0] addr;
  logic [NUM_CH*WIDTH-1:0]      wdata, rdata;
  logic [NUM_CH*WIDTH/8-1:0]    wstrb;
  modport master (output valid, wr_rd, addr, wdata, wstrb, input ready, rvalid, rdata, err);
  modport slave  (input valid, wr_rd, addr, wdata, wstrb, output ready, rvalid, rdata, err);
endinterface

// File: rtl/mem_multi_port.sv
// mem_multi_port: NUM_CH round-robin arbitrated channels sharing one byte-strobed word array
module mem_multi_port #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_CH     = 2
) (
  input logic             clk,
  input logic             rst,
  mem_multi_port_if.slave bus
);
  localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int NB = WIDTH / 8;
  logic [WIDTH-1:0]        mem_q [DEPTH];
  logic [PW-1:0]           rr_q, rr_d, g_idx;
  logic [NUM_CH-1:0]       rvalid_q, err_q;
  logic [NUM_CH*WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0]   g_addr;
  logic [WIDTH-1:0]        g_wdata;
  logic [NB-1:0]           g_wstrb;
  logic                    found, xfer, g_wr, g_in;
  always_comb begin
    found = 1'b0;
    g_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && bus.valid[(int'(rr_q) + k) % NUM_CH]) begin
        found = 1'b1;
        g_idx = PW'((int'(rr_q) + k) % NUM_CH);
      end
    end
    rr_d    = g_idx == PW'(NUM_CH - 1) ? '0 : g_idx + 1'b1;
    g_addr  = bus.addr[g_idx*ADDR_WIDTH +: ADDR_WIDTH];
    g_wdata = bus.wdata[g_idx*WIDTH +: WIDTH];
    g_wstrb = bus.wstrb[g_idx*NB +: NB];
    g_wr    = bus.wr_rd[g_idx];
    g_in    = int'(g_addr) < DEPTH;
    xfer    = found && rst;
  end
  // responses are masked while reset is held so a pending read never surfaces
  assign bus.ready  = xfer ? NUM_CH'(1) << g_idx : '0;
  assign bus.rvalid = rst ? rvalid_q : '0;
  assign bus.err    = rst ? err_q : '0;
  assign bus.rdata  = rst ? rdata_q : '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rr_q     <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= '0;
      err_q    <= '0;
      if (found) begin
        rr_q         <= rr_d;
        err_q[g_idx] <= !g_in;
        if (g_wr && g_in)
          for (int b = 0; b < NB; b++)
            if (g_wstrb[b]) mem_q[g_addr[IW-1:0]][b*8 +: 8] <= g_wdata[b*8 +: 8];
        if (!g_wr) begin
          rvalid_q[g_idx]                <= 1'b1;
          rdata_q[g_idx*WIDTH +: WIDTH]  <= g_in ? mem_q[g_addr[IW-1:0]] : '0;
        end
      end
    end
  end
endmodule
